bridge_timer: RTL and testbench

- Programmable countdown timer that sits on the processor-side device bus as a bridge responder, decoded at 0x0000_7F00–0x0000_7F0B.
- The bridge drives word address, write data and a per-device write enable; the timer returns read data combinationally and raises an interrupt line to the CP0 hardware-interrupt input.
- Two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/bridge_timer.sv | 123 ++++++++++++
 tb/tb_bridge_timer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the bridge-attached countdown timer: register
// offsets, CTRL bit positions, mode codes and FSM state encoding.
package timer_pkg;

   // Word offsets decoded from Addr[3:2]
   localparam logic [1:0] OFF_CTRL   = 2'b00;
   localparam logic [1:0] OFF_PRESET = 2'b01;
   localparam logic [1:0] OFF_COUNT  = 2'b10;

   // CTRL field positions
   localparam int unsigned CTRL_W        = 4;
   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_MODE_LSB = 1;
   localparam int unsigned CTRL_MODE_MSB = 2;
   localparam int unsigned CTRL_IM       = 3;

   // Mode codes; 1x is reserved and treated as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_CNT  = 2'b10,
      ST_INT  = 2'b11
   } state_e;

endpackage : timer_pkg

// File: rtl/bridge_timer.sv
// Programmable countdown timer on the processor device bus.
// Ports:
//   clk   - system clock, all state on rising edge
//   reset - synchronous active-high reset
//   Addr  - word address from bridge (only Addr[3:2] decoded)
//   WE    - range-qualified write enable from bridge
//   Din   - write data from bridge
//   Dout  - combinational read data to bridge
//   IRQ   - interrupt request to CP0 hardware interrupt input
module bridge_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
   parameter int unsigned CNT_W     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
   logic [CNT_W-1:0]  preset_q,   preset_d;
   logic [CNT_W-1:0]  count_q,    count_d;
   logic              irq_pend_q, irq_pend_d;
   state_e            state_q,    state_d;

   logic [1:0] offset;
   logic       en;
   logic       auto_reload;
   logic       unused_bits;

   assign offset      = Addr[3:2];
   assign en          = ctrl_q[CTRL_EN];
   assign auto_reload = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

   // Range decode is done by the bridge; upper address bits and the base are informational
   assign unused_bits = ^{Addr[31:4], BASE_ADDR};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_pend_q <= 1'b0;
         state_q    <= ST_IDLE;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_pend_q <= irq_pend_d;
         state_q    <= state_d;
      end
   end

   // Next-state: FSM first, then bus writes so a CTRL write overrides the FSM
   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_pend_d = irq_pend_q;
      state_d    = state_q;

      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (count_q > CNT_W'(1)) begin
               count_d = count_q - CNT_W'(1);
            end else begin
               // Covers PRESET of 0 and 1 alike; never wraps below zero
               count_d    = '0;
               irq_pend_d = 1'b1;
               state_d    = ST_INT;
            end
         end
         ST_INT: begin
            if (auto_reload) begin
               irq_pend_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (WE) begin
         if (offset == OFF_CTRL) begin
            ctrl_d     = Din[CTRL_W-1:0];
            irq_pend_d = 1'b0;
         end else if (offset == OFF_PRESET) begin
            preset_d = CNT_W'(Din);
         end
      end
   end

   // Read mux, no wait states
   always_comb begin
      Dout = '0;
      unique case (offset)
         OFF_CTRL:   Dout = 32'(ctrl_q);
         OFF_PRESET: Dout = 32'(preset_q);
         OFF_COUNT:  Dout = 32'(count_q);
         default:    Dout = '0;
      endcase
   end

   assign IRQ = irq_pend_q & ctrl_q[CTRL_IM];

endmodule : bridge_timer

// File: tb/tb_bridge_timer.sv
// Directed bench for bridge_timer with hand-computed expectations.
module tb_bridge_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [29:0] BASE_W = 30'h1FC0;

   bridge_timer dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] off, input logic [31:0] data);
      Addr = BASE_W | 30'(off);
      Din  = data;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] off, output logic [31:0] v);
      Addr = BASE_W | 30'(off);
      #1;
      v = Dout;
   endtask

   logic [31:0] v;
   int          pulses;

   initial begin
      reset = 1'b1;
      Addr  = BASE_W;
      WE    = 1'b0;
      Din   = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      for (int i = 0; i < 4; i++) begin
         bus_rd(2'(i), v);
         check($sformatf("rst_rd%0d", i), v, 32'h0);
      end
      check("rst_irq", 32'(IRQ), 32'h0);

      // One-shot, PRESET=5, CTRL=0x9
      bus_wr(2'b01, 32'd5);
      bus_wr(2'b00, 32'h9);          // edge k
      tick();                        // k+1 LOAD
      tick();                        // k+2
      for (int i = 0; i < 5; i++) begin
         bus_rd(2'b10, v);
         check($sformatf("os_cnt%0d", i), v, 32'(5 - i));
         check($sformatf("os_irq_lo%0d", i), 32'(IRQ), 32'h0);
         tick();
      end
      check("os_irq_hi", 32'(IRQ), 32'h1);   // k+7
      tick();
      check("os_irq_held", 32'(IRQ), 32'h1);
      bus_rd(2'b00, v);
      check("os_en_clr", v, 32'h8);
      bus_wr(2'b00, 32'h8);
      check("os_irq_ack", 32'(IRQ), 32'h0);

      // Auto-reload, PRESET=3, CTRL=0xB
      bus_wr(2'b01, 32'd3);
      bus_wr(2'b00, 32'hB);          // edge k
      pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (IRQ) pulses++;
         check($sformatf("ar_irq%0d", i), 32'(IRQ), (i % 5 == 0) ? 32'h1 : 32'h0);
         if (i % 5 == 2 && i >= 7) begin
            bus_rd(2'b10, v);
            check($sformatf("ar_reload%0d", i), v, 32'd3);
         end
      end
      check("ar_pulses", 32'(pulses), 32'd4);
      bus_wr(2'b00, 32'h0);
      tick();
      tick();
      check("ar_stop_irq", 32'(IRQ), 32'h0);

      // PRESET=0, masked
      bus_wr(2'b01, 32'd0);
      bus_wr(2'b00, 32'h1);          // edge k
      tick();
      tick();
      bus_rd(2'b10, v);
      check("p0_cnt", v, 32'h0);
      tick();                        // k+3 INT
      bus_rd(2'b00, v);
      check("p0_ctrl_int", v, 32'h1);
      check("p0_irq_masked", 32'(IRQ), 32'h0);
      tick();                        // k+4 IDLE, En cleared
      bus_rd(2'b00, v);
      check("p0_en_clr", v, 32'h0);
      bus_wr(2'b00, 32'h8);
      check("p0_irq_after_im", 32'(IRQ), 32'h0);
      tick();
      check("p0_irq_after_im2", 32'(IRQ), 32'h0);

      // Reserved mode 10 behaves as one-shot, PRESET=1
      bus_wr(2'b01, 32'd1);
      bus_wr(2'b00, 32'hD);          // edge k
      for (int i = 0; i < 6; i++) tick();
      check("m10_irq_held", 32'(IRQ), 32'h1);
      bus_rd(2'b00, v);
      check("m10_en_clr", v, 32'hC);
      bus_wr(2'b00, 32'h0);
      check("m10_ack", 32'(IRQ), 32'h0);

      // Mid-count PRESET write, then En=0 freeze
      bus_wr(2'b01, 32'd10);
      bus_wr(2'b00, 32'hB);          // edge k
      for (int i = 0; i < 4; i++) tick();
      bus_wr(2'b01, 32'd100);        // edge k+5
      for (int i = 0; i < 6; i++) tick();
      bus_rd(2'b10, v);
      check("mid_cnt_k11", v, 32'd1);
      tick();
      check("mid_irq_k12", 32'(IRQ), 32'h1);
      tick();
      check("mid_irq_k13", 32'(IRQ), 32'h0);
      tick();
      bus_rd(2'b10, v);
      check("mid_reload_k14", v, 32'd100);
      for (int i = 0; i < 5; i++) tick();
      bus_wr(2'b00, 32'h8);          // edge k+20
      bus_rd(2'b10, v);
      check("frz_cnt_k20", v, 32'd94);
      tick();
      bus_rd(2'b10, v);
      check("frz_cnt_k21", v, 32'd94);
      for (int i = 0; i < 4; i++) tick();
      bus_rd(2'b10, v);
      check("frz_cnt_k25", v, 32'd94);
      check("frz_irq", 32'(IRQ), 32'h0);

      // Writes to COUNT/unused offset ignored; CTRL upper bits ignored
      bus_wr(2'b10, 32'h55);
      bus_rd(2'b10, v);
      check("ro_count", v, 32'd94);
      bus_wr(2'b11, 32'hFFFF_FFFF);
      bus_rd(2'b11, v);
      check("ro_off3", v, 32'h0);
      bus_wr(2'b00, 32'hFFFF_FF08);
      bus_rd(2'b00, v);
      check("ctrl_upper", v, 32'h8);

      // Reset mid-count
      bus_wr(2'b01, 32'd5);
      bus_wr(2'b00, 32'h9);          // edge k
      for (int i = 0; i < 5; i++) tick();
      bus_rd(2'b10, v);
      check("rm_cnt_k5", v, 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus_rd(2'b10, v);
      check("rm_cnt", v, 32'h0);
      bus_rd(2'b00, v);
      check("rm_ctrl", v, 32'h0);
      bus_rd(2'b01, v);
      check("rm_preset", v, 32'h0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (IRQ) pulses++;
      end
      check("rm_no_irq", 32'(pulses), 32'd0);
      bus_rd(2'b10, v);
      check("rm_idle_cnt", v, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_bridge_timer
